// File: rtl/sort4_ctrl_pkg.sv
// ============================================================================
// Module   : sort4_ctrl_pkg
// Brief    : Shared types and constants for the 4-entry sort controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sort4_ctrl_pkg;

  localparam int DATA_W    = 4;
  localparam int N_ENTRIES = 4;
  localparam int N_STEPS   = 6;
  localparam int IDX_W     = 2;
  localparam int STEP_W    = 3;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SORT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Lower index of the pair handled at each step of the 4-element network.
  function automatic logic [IDX_W-1:0] step_pair(input logic [STEP_W-1:0] step);
    logic [IDX_W-1:0] j;
    case (step)
      3'd0:    j = 2'd0;
      3'd1:    j = 2'd1;
      3'd2:    j = 2'd2;
      3'd3:    j = 2'd0;
      3'd4:    j = 2'd1;
      default: j = 2'd0;
    endcase
    return j;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sort4_ctrl_cmp.sv
// ============================================================================
// Module   : comparator4b
// Brief    : 4-bit less-than comparator, unsigned or two's-complement.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator4b
  import sort4_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_mode,
  output logic              lt
);

  assign lt = signed_mode ? ($signed(a) < $signed(b)) : (a < b);

endmodule

`default_nettype wire

// File: rtl/sort4_ctrl.sv
// ============================================================================
// Module   : sort4_ctrl
// Brief    : Loads 4 elements, sorts them in place with one shared comparator
//            over a fixed 6-step network, then streams them out in order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sort4_ctrl
  import sort4_ctrl_pkg::*;
#(
  parameter bit ASCEND = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  swap_cnt,
  output logic              done
);

  state_t             r_state;
  state_t             w_next_state;
  logic [DATA_W-1:0]  r_mem [N_ENTRIES];
  logic [IDX_W-1:0]   r_wr_idx;
  logic [IDX_W-1:0]   r_rd_idx;
  logic [STEP_W-1:0]  r_step;
  logic               r_signed;
  logic [CNT_W-1:0]   r_swap_cnt;

  logic               w_accept;
  logic               w_xfer;
  logic [IDX_W-1:0]   w_j;
  logic [IDX_W-1:0]   w_j_nxt;
  logic [DATA_W-1:0]  w_lo;
  logic [DATA_W-1:0]  w_hi;
  logic [DATA_W-1:0]  w_cmp_a;
  logic [DATA_W-1:0]  w_cmp_b;
  logic               w_lt;
  logic               w_swap;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    w_accept     = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        w_accept = in_valid;
        if (in_valid) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid && r_wr_idx == IDX_W'(N_ENTRIES-1)) w_next_state = ST_SORT;
      end
      ST_SORT: begin
        if (r_step == STEP_W'(N_STEPS-1)) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        w_xfer    = out_ready;
        if (out_ready && r_rd_idx == IDX_W'(N_ENTRIES-1)) begin
          done         = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand order folds the sort direction into the single less-than test.
  assign w_j     = step_pair(r_step);
  assign w_j_nxt = w_j + IDX_W'(1);
  assign w_lo    = r_mem[w_j];
  assign w_hi    = r_mem[w_j_nxt];
  assign w_cmp_a = ASCEND ? w_hi : w_lo;
  assign w_cmp_b = ASCEND ? w_lo : w_hi;
  assign w_swap  = (r_state == ST_SORT) && w_lt;

  comparator4b u_cmp (
    .a           (w_cmp_a),
    .b           (w_cmp_b),
    .signed_mode (r_signed),
    .lt          (w_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) r_mem[i] <= '0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_step     <= '0;
      r_signed   <= 1'b0;
      r_swap_cnt <= '0;
    end else begin
      if (w_accept) begin
        if (r_state == ST_IDLE) begin
          r_mem[0]   <= in_data;
          r_wr_idx   <= IDX_W'(1);
          r_signed   <= signed_mode;
          r_swap_cnt <= '0;
        end else begin
          r_mem[r_wr_idx] <= in_data;
          r_wr_idx        <= r_wr_idx + IDX_W'(1);
        end
      end
      if (r_state == ST_SORT) begin
        r_step <= (r_step == STEP_W'(N_STEPS-1)) ? '0 : r_step + STEP_W'(1);
        if (w_swap) begin
          r_mem[w_j]     <= w_hi;
          r_mem[w_j_nxt] <= w_lo;
          if (r_swap_cnt != CNT_W'(N_STEPS)) r_swap_cnt <= r_swap_cnt + CNT_W'(1);
        end
      end
      if (w_xfer) r_rd_idx <= r_rd_idx + IDX_W'(1);
    end
  end

  assign out_data = out_valid ? r_mem[r_rd_idx] : '0;
  assign swap_cnt = r_swap_cnt;

endmodule

`default_nettype wire

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 Parameter ASCEND, default 1, selects sort order: 1 = ascending, 0 = descending.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare; sampled on the first accepted input beat.
REQ-005 in_valid  input  1  in_data holds a valid element.
REQ-006 in_data  input  4  element to load.
REQ-007 in_ready  output  1  block accepts an element this cycle.
REQ-008 out_valid  output  1  out_data holds a valid sorted element.
REQ-009 out_data  output  4  sorted element, emitted in index order 0..3.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 busy  output  1  high in LOAD, SORT and DRAIN.
REQ-012 swap_cnt  output  3  number of swaps performed in the current or last sort, range 0..6.
REQ-013 done  output  1  one-cycle pulse on the cycle the 4th element is accepted downstream.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, SORT and DRAIN.
REQ-015 A beat SHALL transfer when in_valid & in_ready; in_ready SHALL be 1 in IDLE and LOAD and 0 otherwise.
REQ-016 The first beat accepted in IDLE SHALL be written to mem[0], latch signed_mode, clear swap_cnt, and move the FSM to LOAD.
REQ-017 Subsequent beats SHALL fill mem[1..3] in order; the cycle after the 4th beat is accepted, the FSM SHALL be in SORT.
REQ-018 SORT SHALL last exactly 6 cycles, one compare-swap per cycle, on the fixed pair sequence (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
REQ-019 Each step SHALL drive one shared comparator with A = mem[j+1], B = mem[j] when ASCEND=1, or A = mem[j], B = mem[j+1] when ASCEND=0.
REQ-020 The two elements SHALL swap only when the comparator's less-than output is 1 (SLTu if latched mode = 0, SLT if 1); equal values SHALL NOT swap (stable sort).
REQ-021 Each swap SHALL increment swap_cnt by 1; swap_cnt SHALL saturate at 6 and hold its value until the next sort starts.
REQ-022 After the 6th step the FSM SHALL enter DRAIN; if the 4th beat is accepted on cycle T, out_valid SHALL first be 1 on cycle T+7.
REQ-023 In DRAIN, out_data SHALL equal mem[rd_idx]; rd_idx SHALL advance only when out_valid & out_ready.
REQ-024 While out_ready = 0, out_valid and out_data SHALL remain stable.
REQ-025 When the 4th output transfers, done SHALL pulse for that cycle and the FSM SHALL return to IDLE on the next cycle.
REQ-026 in_valid SHALL be ignored outside IDLE and LOAD; no partial sort SHALL occur before 4 elements are loaded.

Reset
REQ-027 When rst = 1 at a clock edge, the block SHALL enter IDLE with in_ready = 1, out_valid = 0, busy = 0, done = 0, swap_cnt = 0, out_data = 0, all indices = 0 and mem cleared.
REQ-028 Reset SHALL take effect in any state, including mid-SORT and mid-DRAIN, and SHALL discard all loaded data.

Structure
REQ-029 A shared header SHALL define the state encodings, the element width (4), the entry count (4) and the number of sort steps (6).
REQ-030 The block SHALL instantiate exactly one Comparator4b as its sole compare resource; no other comparison logic SHALL exist.

Verification
REQ-031 Unsigned, ASCEND=1, input 7,E,3,6 -> output 3,6,7,E with swap_cnt = 4.
REQ-032 Signed, ASCEND=1, input 7,E,3,6 -> output E,3,6,7 with swap_cnt = 3.
REQ-033 Unsigned, input F,C,8,0 -> output 0,8,C,F with swap_cnt = 6; input 6,6,6,6 -> output 6,6,6,6 with swap_cnt = 0.
REQ-034 Latency and backpressure: 4th beat accepted on cycle T -> out_valid first on cycle T+7; out_ready held 0 for 3 cycles -> out_data held at the first element; done pulses once, on the 4th transfer.
REQ-035 rst asserted during the 3rd SORT cycle -> next cycle shows in_ready = 1, busy = 0, out_valid = 0; a fresh load of 1,2,3,4 sorts to 1,2,3,4 with swap_cnt = 0.
REQ-036 ASCEND=0, unsigned, input 3,6,7,E -> output E,7,6,3 with swap_cnt = 6.
